// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding, default geometry,
// and the counter-width helper used by the top level.
package serial_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] S_HUNT  = 3'd0;
  localparam logic [STATE_W-1:0] S_IDLE  = 3'd1;
  localparam logic [STATE_W-1:0] S_START = 3'd2;
  localparam logic [STATE_W-1:0] S_DATA  = 3'd3;
  localparam logic [STATE_W-1:0] S_PAR   = 3'd4;
  localparam logic [STATE_W-1:0] S_STOP  = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    HUNT  = S_HUNT,
    IDLE  = S_IDLE,
    START = S_START,
    DATA  = S_DATA,
    PAR   = S_PAR,
    STOP  = S_STOP
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;

  // The bit counter is also used to flush the synchroniser after reset, so it
  // must be able to count to 2 even for the smallest DIV.
  function automatic int cnt_width(input int div);
    return (div > 4) ? $clog2(div) : 2;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-stage rising-edge synchroniser for the serial input; both stages reset to
// the idle line level (1).
module bit_sync (
  input  logic CK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= D;
      sync_q <= meta_q;
    end
  end

  assign Q = sync_q;

endmodule

// File: rtl/serial_rx.sv
// Async-framed serial receiver: synchroniser, mid-bit sampling FSM, shift register
// and a one-word valid/ready holding register. Optional parity via SERIAL_RX_PARITY_EN.
module serial_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic             SIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic             FERR,
  output logic             OVR,
  output logic             PERR
);

  localparam int CNT_W = cnt_width(DIV);
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRIMED = CNT_W'(2);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WIDTH - 1);

  logic             s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] dout_q;
  logic             dvalid_q;
  logic             ferr_q;
  logic             ovr_q;
  logic             perr_q;
  logic             par_bad;
  logic             tick_full;

  bit_sync u_sync (
    .CK    (CK),
    .RST_N (RST_N),
    .D     (SIN),
    .Q     (s)
  );

  assign tick_full = (cnt_q == CNT_FULL);

`ifdef SERIAL_RX_PARITY_EN
  logic par_q;
  assign par_bad = par_q;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      perr_q <= 1'b0;
      if (dvalid_q && DREADY) begin
        dvalid_q <= 1'b0;
      end

      case (state_q)
        // Wait until the synchroniser holds post-reset samples, then for a real idle level.
        HUNT: begin
          if (cnt_q != CNT_PRIMED) begin
            cnt_q <= cnt_q + 1'b1;
          end else if (s) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end

        IDLE: begin
          if (!s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (s) begin
              state_q <= IDLE;
            end else begin
              state_q <= DATA;
              idx_q   <= '0;
`ifdef SERIAL_RX_PARITY_EN
              par_q   <= 1'b0;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (tick_full) begin
            cnt_q   <= '0;
            shift_q <= (shift_q >> 1) | (WIDTH'(s) << (WIDTH - 1));
            idx_q   <= idx_q + 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            par_q   <= par_q ^ s;
`endif
            if (idx_q == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
              state_q <= PAR;
`else
              state_q <= STOP;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef SERIAL_RX_PARITY_EN
        PAR: begin
          if (tick_full) begin
            cnt_q   <= '0;
            par_q   <= par_q ^ s;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        // A framing error outranks parity; only a clean frame reaches the holding register.
        STOP: begin
          if (tick_full) begin
            cnt_q <= '0;
            if (!s) begin
              ferr_q  <= 1'b1;
              state_q <= HUNT;
            end else begin
              state_q <= IDLE;
              if (par_bad) begin
                perr_q <= 1'b1;
              end else if (dvalid_q && !DREADY) begin
                ovr_q <= 1'b1;
              end else begin
                dout_q   <= shift_q;
                dvalid_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= HUNT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign FERR   = ferr_q;
  assign OVR    = ovr_q;
  assign PERR   = perr_q;

endmodule

// File: tb/tb_serial_rx.sv
// Directed plus randomized bench for serial_rx; frame outcomes and timing come from
// a frame-level model (bit timing formula, holding-register occupancy, flag rules).
module tb_serial_rx;

  localparam int W = 8;
  localparam int D = 4;
`ifdef SERIAL_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 2 + D / 2 + (W + 1 + P) * D;

  logic         CK = 1'b0;
  logic         RST_N = 1'b0;
  logic         SIN = 1'b1;
  logic         DREADY = 1'b1;
  logic [W-1:0] DOUT;
  logic         DVALID;
  logic         FERR;
  logic         OVR;
  logic         PERR;

  serial_rx #(.WIDTH(W), .DIV(D)) dut (
    .CK     (CK),
    .RST_N  (RST_N),
    .SIN    (SIN),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .DREADY (DREADY),
    .FERR   (FERR),
    .OVR    (OVR),
    .PERR   (PERR)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // Observed flag activity, accumulated over the whole run.
  int ferr_hi = 0, ovr_hi = 0, perr_hi = 0, multi_hi = 0, dv_hi = 0;
  always @(negedge CK) begin
    if (FERR) ferr_hi++;
    if (OVR) ovr_hi++;
    if (PERR) perr_hi++;
    if (int'(FERR) + int'(OVR) + int'(PERR) > 1) multi_hi++;
    if (DVALID) dv_hi++;
  end

  // Reference model state.
  logic [W-1:0] m_dout = '0;
  logic         m_valid = 1'b0;
  int ferr_exp = 0, ovr_exp = 0, perr_exp = 0;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CK);
      #1;
    end
  endtask

  task automatic idle(input int n);
    tick(n);
    if (n > 0 && DREADY) m_valid = 1'b0;
  endtask

  task automatic await_cyc(input int e);
    int g;
    g = 0;
    while (cyc < e && g < 2000) begin
      tick(1);
      g++;
    end
    chk("await_cyc", cyc, e);
  endtask

  task automatic send_bits(input logic [W-1:0] data, input bit stop, input bit par_bad,
                           output int k);
    k = cyc + 1;
    SIN = 1'b0;
    tick(D);
    for (int i = 0; i < W; i++) begin
      SIN = data[i];
      tick(D);
    end
    if (P == 1) begin
      SIN = (^data) ^ par_bad;
      tick(D);
    end
    SIN = stop;
    tick(D);
  endtask

  task automatic frame(input logic [W-1:0] data, input bit stop, input bit par_bad,
                       input bit rdy_final, input string tag);
    int    k;
    bit    e_f, e_p, e_o;
    string res;
    if (DREADY) m_valid = 1'b0;
    send_bits(data, stop, par_bad, k);
    await_cyc(k + LAT - 1);
    chk({tag, ".pre_dvalid"}, DVALID, m_valid);
    DREADY = rdy_final;
    tick(1);
    e_f = 0; e_p = 0; e_o = 0;
    if (!stop) begin
      e_f = 1; res = "FERR";
    end else if (par_bad) begin
      e_p = 1; res = "PERR";
    end else if (m_valid && !rdy_final) begin
      e_o = 1; res = "OVR";
    end else begin
      m_dout = data; m_valid = 1'b1; res = "WORD";
    end
    if ((e_f || e_p) && m_valid && rdy_final) m_valid = 1'b0;
    ferr_exp += int'(e_f);
    perr_exp += int'(e_p);
    ovr_exp  += int'(e_o);
    chk({tag, ".ferr"}, FERR, e_f);
    chk({tag, ".perr"}, PERR, e_p);
    chk({tag, ".ovr"}, OVR, e_o);
    chk({tag, ".dvalid"}, DVALID, m_valid);
    chk({tag, ".dout"}, DOUT, m_dout);
    $display("frame %s: data=0x%02h stop=%0d par_bad=%0d start_edge=%0d result=%s",
             tag, data, stop, par_bad, k, res);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: observed no finish, expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    int dv0, fl0;
    logic [W-1:0] r;

    // Reset state
    tick(3);
    chk("rst.dout", DOUT, 0);
    chk("rst.dvalid", DVALID, 0);
    chk("rst.ferr", FERR, 0);
    chk("rst.ovr", OVR, 0);
    chk("rst.perr", PERR, 0);
    RST_N = 1'b1;
    tick(6);

    // 1: plain word, one-cycle DVALID with DREADY high
    frame(8'hA5, 1, 0, 1, "t1");
    idle(1);
    chk("t1.dvalid_fall", DVALID, m_valid);
    chk("t1.dout_hold", DOUT, 8'hA5);

    // 2: one-clock glitch is a false start
    dv0 = dv_hi; fl0 = ferr_hi + ovr_hi + perr_hi;
    SIN = 1'b0; tick(1); SIN = 1'b1;
    idle(12);
    chk("t2.no_dvalid", dv_hi, dv0);
    chk("t2.no_flags", ferr_hi + ovr_hi + perr_hi, fl0);
    frame(8'h5A, 1, 0, 1, "t2");
    idle(2);

    // 3: framing error, line held low for three bit periods
    frame(8'h3C, 0, 0, 1, "t3");
    dv0 = dv_hi; fl0 = ferr_hi + ovr_hi + perr_hi;
    tick(3 * D - D - 1);
    SIN = 1'b1;
    idle(50);
    chk("t3.no_dvalid", dv_hi, dv0);
    chk("t3.no_flags", ferr_hi + ovr_hi + perr_hi, fl0);

    // 4: overrun while holding register is full
    DREADY = 1'b0;
    frame(8'h11, 1, 0, 0, "t4a");
    idle(2);
    frame(8'h22, 1, 0, 0, "t4b");
    DREADY = 1'b1; idle(1); DREADY = 1'b0;
    chk("t4.dvalid_taken", DVALID, m_valid);
    chk("t4.dout_hold", DOUT, 8'h11);

    // 5: async reset mid-frame, released with the line low
    r = 8'($urandom);
    frame(r, 1, 0, 0, "t5_hold");
    idle(3);
    SIN = 1'b0; tick(D);
    for (int i = 0; i < 3; i++) begin
      SIN = 1'b1; tick(D);
    end
    SIN = 1'b0; tick(2);
    #2 RST_N = 1'b0;
    #1;
    m_valid = 1'b0; m_dout = '0;
    chk("t5.dout_async", DOUT, 0);
    chk("t5.dvalid_async", DVALID, 0);
    tick(2);
    dv0 = dv_hi; fl0 = ferr_hi + ovr_hi + perr_hi;
    RST_N = 1'b1;
    idle(50);
    chk("t5.no_dvalid", dv_hi, dv0);
    chk("t5.no_flags", ferr_hi + ovr_hi + perr_hi, fl0);
    SIN = 1'b1; DREADY = 1'b1;
    idle(6);
    frame(8'hFF, 1, 0, 1, "t5");
    idle(1);

    // 6: consumer takes the old word on the edge the new one completes
    DREADY = 1'b0;
    frame(8'h6B, 1, 0, 0, "t6a");
    frame(8'h94, 1, 0, 1, "t6b");
    idle(1);
    chk("t6.dvalid_taken", DVALID, m_valid);

`ifdef SERIAL_RX_PARITY_EN
    // 7: parity
    DREADY = 1'b1;
    idle(2);
    frame(8'h07, 1, 1, 1, "t7_bad");
    idle(3);
    frame(8'h07, 1, 0, 1, "t7_good");
    idle(1);
`endif

    // Randomized frames against the model
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] d;
      bit stop, pb, rf;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pb   = (P == 1) && ($urandom_range(0, 3) == 0);
      rf   = 1'($urandom_range(0, 1));
      DREADY = 1'($urandom_range(0, 1));
      idle($urandom_range(1, 6));
      frame(d, stop, pb, rf, $sformatf("rnd%0d", i));
      if (!stop) begin
        SIN = 1'b1;
        idle(6);
      end
    end
    idle(4);

    chk("total.ferr_cycles", ferr_hi, ferr_exp);
    chk("total.ovr_cycles", ovr_hi, ovr_exp);
    chk("total.perr_cycles", perr_hi, perr_exp);
    chk("total.flag_overlap", multi_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
